// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the instruction memory responder.
// Holds the response bundle, the latency ceiling and the index-width helper.
package instr_mem_pkg;

    localparam int MAX_LATENCY = 4;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } resp_t;

    function automatic int clog2(input int words);
        int w;
        w = 0;
        while ((1 << w) < words) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/instr_mem_resp_pipe.sv
// LATENCY-deep shift register carrying {valid, err, data} responses.
// Ports: clk, rstn, resp_i (grant-stage entry), resp_o (oldest stage).
module instr_mem_resp_pipe
    import instr_mem_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic  clk,
    input  logic  rstn,
    input  resp_t resp_i,
    output resp_t resp_o
);

    // Out-of-range depths are clamped to the supported 1..MAX_LATENCY.
    localparam int DEPTH = (LATENCY > MAX_LATENCY) ? MAX_LATENCY :
                           (LATENCY < 1) ? 1 : LATENCY;

    resp_t stage_q [DEPTH];
    resp_t stage_d [DEPTH];

    always_comb begin
        stage_d[0] = resp_i;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign resp_o = stage_q[DEPTH-1];

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction memory with req/gnt/rvalid fetch port and a program-load port.
// Ports: clk, rstn, instr_req/gnt/addr/rdata/rvalid/err, load_we/addr/wdata.
module instr_mem_responder
    import instr_mem_pkg::*;
#(
    parameter int          MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0,
    parameter int          LATENCY         = 1,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_rvalid_o,
    output logic        instr_err_o,
    input  logic        load_we_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_wdata_i
);

    localparam int          IW   = clog2(MEM_WORDS);
    localparam logic [33:0] SPAN = 34'(MEM_WORDS) << 2;

    logic [31:0] mem_q [MEM_WORDS];

    logic [33:0]   rd_off;
    logic [33:0]   ld_off;
    logic          rd_hit;
    logic          ld_hit;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] ld_idx;

    logic  [2:0] outstanding_cnt_q;
    logic  [2:0] outstanding_cnt_d;
    logic        gnt;
    logic        retire;
    resp_t       resp_in;
    resp_t       resp_out;

    // 34-bit offsets keep the range test free of 32-bit wrap.
    always_comb begin
        rd_off = {2'b00, instr_addr_i} - {2'b00, BASE_ADDR};
        ld_off = {2'b00, load_addr_i} - {2'b00, BASE_ADDR};
        rd_hit = (instr_addr_i >= BASE_ADDR) && (rd_off < SPAN);
        ld_hit = (load_addr_i >= BASE_ADDR) && (ld_off < SPAN);
        rd_idx = rd_off[IW+1:2];
        ld_idx = ld_off[IW+1:2];
    end

    // A retiring response frees its slot in the same cycle.
    assign retire = resp_out.valid;
    assign gnt    = rstn && instr_req_i &&
                    ((outstanding_cnt_q < 3'(MAX_OUTSTANDING)) || retire);

    always_comb begin
        resp_in.valid = gnt;
        resp_in.err   = gnt && !rd_hit;
        resp_in.data  = (gnt && rd_hit) ? mem_q[rd_idx] : 32'h0;
    end

    always_comb begin
        outstanding_cnt_d = outstanding_cnt_q;
        unique case (1'b1)
            (gnt && !retire): outstanding_cnt_d = outstanding_cnt_q + 3'd1;
            (retire && !gnt): outstanding_cnt_d = outstanding_cnt_q - 3'd1;
            default:          outstanding_cnt_d = outstanding_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outstanding_cnt_q <= 3'd0;
        end else begin
            outstanding_cnt_q <= outstanding_cnt_d;
        end
    end

    // Memory is deliberately not reset; a same-edge load is seen by
    // the next grant only, since the read was captured this edge.
    always_ff @(posedge clk) begin
        if (load_we_i && ld_hit) begin
            mem_q[ld_idx] <= load_wdata_i;
        end
    end

    instr_mem_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk    (clk),
        .rstn   (rstn),
        .resp_i (resp_in),
        .resp_o (resp_out)
    );

    assign instr_gnt_o    = gnt;
    assign instr_rvalid_o = resp_out.valid;
    assign instr_err_o    = resp_out.valid && resp_out.err;
    assign instr_rdata_o  = resp_out.valid ? resp_out.data : 32'h0;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench: LATENCY=1 and LATENCY=3 instances on shared stimulus,
// directed scenarios plus random traffic against a queue-based reference.
module tb_instr_mem_responder;

    localparam int     WORDS = 1024;
    localparam int     MAXO  = 2;
    localparam longint BASE  = 0;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req;
    logic        lwe;
    logic [31:0] addr;
    logic [31:0] laddr;
    logic [31:0] lwdata;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [1:0]  err;
    logic [31:0] rdata0;
    logic [31:0] rdata1;

    always #5 clk = ~clk;

    instr_mem_responder #(
        .MEM_WORDS(WORDS), .BASE_ADDR(32'h0),
        .LATENCY(1), .MAX_OUTSTANDING(MAXO)
    ) u_l1 (
        .clk(clk), .rstn(rstn),
        .instr_req_i(req), .instr_gnt_o(gnt[0]),
        .instr_addr_i(addr), .instr_rdata_o(rdata0),
        .instr_rvalid_o(rvalid[0]), .instr_err_o(err[0]),
        .load_we_i(lwe), .load_addr_i(laddr), .load_wdata_i(lwdata)
    );

    instr_mem_responder #(
        .MEM_WORDS(WORDS), .BASE_ADDR(32'h0),
        .LATENCY(3), .MAX_OUTSTANDING(MAXO)
    ) u_l3 (
        .clk(clk), .rstn(rstn),
        .instr_req_i(req), .instr_gnt_o(gnt[1]),
        .instr_addr_i(addr), .instr_rdata_o(rdata1),
        .instr_rvalid_o(rvalid[1]), .instr_err_o(err[1]),
        .load_we_i(lwe), .load_addr_i(laddr), .load_wdata_i(lwdata)
    );

    typedef struct {
        int          due;
        logic        e;
        logic [31:0] d;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] ref_mem [WORDS];
    int          cyc;
    int          checks;
    int          errors;
    logic [1:0]  exp_gnt;
    logic [1:0]  exp_rv;
    logic [1:0]  exp_err;
    logic [31:0] exp_rd [2];

    function automatic bit in_rng(logic [31:0] a);
        longint off;
        off = longint'({32'h0, a}) - BASE;
        return (off >= 0) && (off < 4 * WORDS);
    endfunction

    function automatic int widx(logic [31:0] a);
        return int'((longint'({32'h0, a}) - BASE) >>> 2);
    endfunction

    function automatic logic [31:0] dut_rdata(int k);
        return (k == 0) ? rdata0 : rdata1;
    endfunction

    // Expected port values for the current cycle from the pending queues.
    function automatic void model_eval();
        exp_t f;
        int   sz;
        bit   ret;
        for (int k = 0; k < 2; k++) begin
            sz  = (k == 0) ? q0.size() : q1.size();
            ret = 1'b0;
            if (sz > 0) begin
                f   = (k == 0) ? q0[0] : q1[0];
                ret = (f.due == cyc);
            end
            exp_rv[k]  = rstn && ret;
            exp_err[k] = rstn && ret && f.e;
            exp_rd[k]  = (rstn && ret) ? f.d : 32'h0;
            exp_gnt[k] = rstn && req && ((sz < MAXO) || ret);
        end
    endfunction

    task automatic advance();
        exp_t ent;
        model_eval();
        for (int k = 0; k < 2; k++) begin
            if (!rstn) begin
                if (k == 0) q0.delete(); else q1.delete();
            end else begin
                if (exp_rv[k]) begin
                    if (k == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                end
                if (exp_gnt[k]) begin
                    ent.due = cyc + ((k == 0) ? 1 : 3);
                    ent.e   = !in_rng(addr);
                    ent.d   = in_rng(addr) ? ref_mem[widx(addr)] : 32'h0;
                    if (k == 0) q0.push_back(ent); else q1.push_back(ent);
                end
            end
        end
        if (lwe && in_rng(laddr)) ref_mem[widx(laddr)] = lwdata;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic idle(int n);
        req = 1'b0;
        lwe = 1'b0;
        repeat (n) advance();
    endtask

    task automatic test_reset();
        rstn = 1'b1; req = 1'b0; lwe = 1'b0;
        addr = '0; laddr = '0; lwdata = '0;
        #2 rstn = 1'b0;
        req = 1'b1;
        #1;
        checks++;
        if (gnt !== 2'b00) begin
            errors++; $display("FAIL reset_gnt: got %b want 00", gnt);
        end
        checks++;
        if (rvalid !== 2'b00 || err !== 2'b00) begin
            errors++;
            $display("FAIL reset_rv_err: got rv=%b err=%b want 00", rvalid, err);
        end
        checks++;
        if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h/%h want 0", rdata0, rdata1);
        end
        checks++;
        if (u_l3.outstanding_cnt_q !== 3'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d want 0", u_l3.outstanding_cnt_q);
        end
        advance();
        advance();
        rstn = 1'b1;
        idle(2);
    endtask

    task automatic preload();
        for (int i = 0; i < 64; i++) begin
            lwe   = 1'b1;
            laddr = 32'(i * 4);
            case (i)
                0:       lwdata = 32'h0000_0013;
                1:       lwdata = 32'h1111_1111;
                2:       lwdata = 32'h2222_2222;
                default: lwdata = $urandom;
            endcase
            advance();
        end
        laddr  = 32'hFFC;
        lwdata = 32'hCAFE_F00D;
        advance();
        lwe = 1'b0;
    endtask

    task automatic test_latency1();
        req = 1'b1; addr = 32'h0;
        settle();
        checks++;
        if (gnt !== 2'b11) begin
            errors++; $display("FAIL lat1_gnt: got %b want 11", gnt);
        end
        advance();
        req = 1'b0;
        settle();
        checks++;
        if (rvalid[0] !== 1'b1 || rdata0 !== 32'h13 || err[0] !== 1'b0) begin
            errors++;
            $display("FAIL lat1_resp: got rv=%b d=%h e=%b want 1/00000013/0",
                     rvalid[0], rdata0, err[0]);
        end
        advance();
        settle();
        checks++;
        if (rvalid !== 2'b00) begin
            errors++; $display("FAIL lat1_single: got rv=%b want 00", rvalid);
        end
        advance();
        settle();
        checks++;
        if (rvalid[1] !== 1'b1 || rdata1 !== 32'h13) begin
            errors++;
            $display("FAIL lat3_resp: got rv=%b d=%h want 1/00000013",
                     rvalid[1], rdata1);
        end
        idle(3);
    endtask

    task automatic test_outstanding();
        logic [5:0] g_pat;
        logic [5:0] v_pat;
        g_pat = 6'b011011;
        v_pat = 6'b011000;
        for (int i = 0; i < 6; i++) begin
            req  = 1'b1;
            addr = 32'(i * 4);
            settle();
            checks++;
            if (gnt[1] !== g_pat[i] || rvalid[1] !== v_pat[i]) begin
                errors++;
                $display("FAIL outst_c%0d: got gnt=%b rv=%b want %b/%b",
                         i, gnt[1], rvalid[1], g_pat[i], v_pat[i]);
            end
            checks++;
            if (gnt[0] !== 1'b1) begin
                errors++; $display("FAIL outst_l1_gnt c%0d: got 0 want 1", i);
            end
            if (i == 3 || i == 4) begin
                checks++;
                if (rdata1 !== ((i == 3) ? 32'h13 : 32'h1111_1111)) begin
                    errors++;
                    $display("FAIL outst_order c%0d: got %h", i, rdata1);
                end
            end
            advance();
        end
        idle(5);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            req  = 1'b1;
            addr = 32'(i * 4);
            settle();
            checks++;
            if (gnt[0] !== 1'b1) begin
                errors++; $display("FAIL b2b_gnt c%0d: got 0 want 1", i);
            end
            if (i > 0) begin
                checks++;
                if (rvalid[0] !== 1'b1 || rdata0 !== ref_mem[i-1]) begin
                    errors++;
                    $display("FAIL b2b_data c%0d: got rv=%b d=%h want 1/%h",
                             i, rvalid[0], rdata0, ref_mem[i-1]);
                end
            end
            advance();
        end
        req = 1'b0;
        settle();
        checks++;
        if (rvalid[0] !== 1'b1 || rdata0 !== ref_mem[7]) begin
            errors++;
            $display("FAIL b2b_last: got rv=%b d=%h want 1/%h",
                     rvalid[0], rdata0, ref_mem[7]);
        end
        idle(5);
    endtask

    task automatic test_range();
        logic [31:0] a_tab [5];
        logic        e_tab [5];
        logic [31:0] d_tab [5];
        a_tab = '{32'h1000, 32'hFFC, 32'h6, 32'hFFFF_FFFC, 32'h1FFC};
        e_tab = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        d_tab = '{32'h0, 32'hCAFE_F00D, 32'h1111_1111, 32'h0, 32'h0};
        for (int i = 0; i < 5; i++) begin
            req  = 1'b1;
            addr = a_tab[i];
            advance();
            req = 1'b0;
            settle();
            checks++;
            if (rvalid[0] !== 1'b1 || err[0] !== e_tab[i] ||
                rdata0 !== d_tab[i]) begin
                errors++;
                $display("FAIL range_%h: got rv=%b e=%b d=%h want 1/%b/%h",
                         a_tab[i], rvalid[0], err[0], rdata0, e_tab[i], d_tab[i]);
            end
            idle(3);
        end
    endtask

    task automatic test_load_collision();
        req = 1'b1; addr = 32'h8;
        lwe = 1'b1; laddr = 32'h8; lwdata = 32'hDEAD_BEEF;
        settle();
        checks++;
        if (gnt[0] !== 1'b1) begin
            errors++; $display("FAIL coll_gnt: got 0 want 1");
        end
        advance();
        lwe = 1'b0;
        settle();
        checks++;
        if (rvalid[0] !== 1'b1 || rdata0 !== 32'h2222_2222) begin
            errors++;
            $display("FAIL coll_old: got rv=%b d=%h want 1/22222222",
                     rvalid[0], rdata0);
        end
        advance();
        req = 1'b0;
        settle();
        checks++;
        if (rvalid[0] !== 1'b1 || rdata0 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL coll_new: got rv=%b d=%h want 1/deadbeef",
                     rvalid[0], rdata0);
        end
        idle(4);
        lwe = 1'b1; laddr = 32'h1000; lwdata = 32'hBAD0_BAD0;
        advance();
        lwe = 1'b0; req = 1'b1; addr = 32'h0;
        advance();
        req = 1'b0;
        settle();
        checks++;
        if (rdata0 !== 32'h13) begin
            errors++; $display("FAIL load_drop: got %h want 00000013", rdata0);
        end
        idle(4);
    endtask

    task automatic test_reset_mid();
        req = 1'b1; addr = 32'h0;
        advance();
        addr = 32'h4;
        advance();
        rstn = 1'b0;
        req  = 1'b0;
        settle();
        checks++;
        if (rvalid !== 2'b00 || gnt !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_hold: got rv=%b gnt=%b want 00/00", rvalid, gnt);
        end
        advance();
        advance();
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            settle();
            checks++;
            if (rvalid !== 2'b00) begin
                errors++;
                $display("FAIL rstmid_rv c%0d: got %b want 00", i, rvalid);
            end
            advance();
        end
        checks++;
        if (u_l1.outstanding_cnt_q !== 3'd0 || u_l3.outstanding_cnt_q !== 3'd0) begin
            errors++;
            $display("FAIL rstmid_cnt: got %0d/%0d want 0/0",
                     u_l1.outstanding_cnt_q, u_l3.outstanding_cnt_q);
        end
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 400; n++) begin
            req = ($urandom_range(0, 9) < 7);
            r   = $urandom_range(0, 9);
            if (r < 7)       addr = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
            else if (r == 7) addr = 32'hFFC + 32'($urandom_range(0, 3));
            else if (r == 8) addr = 32'h1000 + 32'($urandom_range(0, 255) * 4);
            else             addr = 32'hF000_0000 | $urandom;
            lwe    = ($urandom_range(0, 3) == 0);
            laddr  = 32'($urandom_range(0, 63) * 4);
            if ($urandom_range(0, 1) == 1) laddr = laddr + 32'h1000;
            lwdata = $urandom;
            settle();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (gnt[k] !== exp_gnt[k]) begin
                    errors++;
                    $display("FAIL rnd_gnt%0d cyc %0d: got %b want %b",
                             k, cyc, gnt[k], exp_gnt[k]);
                end
                checks++;
                if (rvalid[k] !== exp_rv[k]) begin
                    errors++;
                    $display("FAIL rnd_rv%0d cyc %0d: got %b want %b",
                             k, cyc, rvalid[k], exp_rv[k]);
                end
                checks++;
                if (err[k] !== exp_err[k]) begin
                    errors++;
                    $display("FAIL rnd_err%0d cyc %0d: got %b want %b",
                             k, cyc, err[k], exp_err[k]);
                end
                checks++;
                if (dut_rdata(k) !== exp_rd[k]) begin
                    errors++;
                    $display("FAIL rnd_rdata%0d cyc %0d: got %h want %h",
                             k, cyc, dut_rdata(k), exp_rd[k]);
                end
            end
            advance();
        end
        idle(5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        test_reset();
        preload();
        test_latency1();
        test_outstanding();
        test_back_to_back();
        test_range();
        test_load_collision();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
